// File: rtl/param_code_lock.sv
// Parametrised keypad code lock: N-digit user code, M-digit super code,
// two-pass code change, wrong-attempt lockout and inter-key timeout.
module param_code_lock #(
  parameter int unsigned                 PW_LEN         = 4,
  parameter int unsigned                 SUPER_LEN      = 6,
  parameter logic [PW_LEN*4-1:0]         DEFAULT_PW     = 16'h1234,
  parameter logic [SUPER_LEN*4-1:0]      SUPER_PW       = 24'h230419,
  parameter int unsigned                 MAX_WRONG      = 3,
  parameter int unsigned                 OPEN_CYCLES    = 3,
  parameter int unsigned                 LOCK_CYCLES    = 3,
  parameter int unsigned                 TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               clr_n,
  input  logic                               key_valid,
  input  logic [3:0]                         din,
  input  logic                               cancel,
  input  logic                               confirm,
  output logic                               unlock_ok,
  output logic                               locking,
  output logic                               reset_ok,
  output logic                               err_pulse,
  output logic [$clog2(MAX_WRONG+1)-1:0]     wrong_cnt,
  output logic [3:0]                         digit_cnt
);

  localparam int unsigned PW_W    = PW_LEN * 4;
  localparam int unsigned BUF_W   = SUPER_LEN * 4;
  localparam int unsigned WC_W    = $clog2(MAX_WRONG + 1);
  localparam int unsigned TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned OVF_CNT = SUPER_LEN + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPEN   = 3'd1,
    S_LOCKED = 3'd2,
    S_NEW1   = 3'd3,
    S_NEW2   = 3'd4
  } state_t;

  state_t             state;
  logic [BUF_W-1:0]   ent_buf;
  logic [PW_W-1:0]    user_pw;
  logic [PW_W-1:0]    cand_pw;
  logic [TMR_W-1:0]   tmr;
  logic [IDLE_W-1:0]  idle_cnt;

  logic               key_digit_c;
  logic               tmo_active_c;
  logic               tmo_hit_c;
  logic               len_pw_c;
  logic               len_super_c;
  logic [3:0]         cnt_inc_c;
  logic [BUF_W-1:0]   buf_shift_c;

  // Decode the strobe: confirm beats cancel beats digit; only 0..9 are digits.
  assign key_digit_c  = key_valid && !confirm && !cancel && (din <= 4'd9);
  // Partial entry is subject to the inter-key timeout.
  assign tmo_active_c = ((state == S_IDLE) && (digit_cnt != 4'd0)) ||
                        (state == S_NEW1) || (state == S_NEW2);
  assign tmo_hit_c    = tmo_active_c && !key_valid &&
                        (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign len_pw_c     = (digit_cnt == 4'(PW_LEN));
  assign len_super_c  = (digit_cnt == 4'(SUPER_LEN));
  // Digit count saturates one past the super length to mark overflow.
  assign cnt_inc_c    = (digit_cnt == 4'(OVF_CNT)) ? digit_cnt : digit_cnt + 4'd1;
  assign buf_shift_c  = {ent_buf[BUF_W-5:0], din};

  // Lock state machine with registered outputs, entry buffer and timers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      unlock_ok <= 1'b0;
      locking   <= 1'b0;
      reset_ok  <= 1'b0;
      err_pulse <= 1'b0;
      wrong_cnt <= '0;
      digit_cnt <= '0;
      ent_buf   <= '0;
      user_pw   <= DEFAULT_PW;
      cand_pw   <= '0;
      tmr       <= '0;
      idle_cnt  <= '0;
    end else begin
      reset_ok  <= 1'b0;
      err_pulse <= 1'b0;

      if (key_valid || !tmo_active_c || tmo_hit_c) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (tmo_hit_c) begin
            ent_buf   <= '0;
            digit_cnt <= '0;
          end else if (key_valid && confirm) begin
            ent_buf   <= '0;
            digit_cnt <= '0;
            if (len_pw_c && (ent_buf[PW_W-1:0] == user_pw)) begin
              state     <= S_OPEN;
              unlock_ok <= 1'b1;
              tmr       <= '0;
              wrong_cnt <= '0;
            end else if (len_super_c && (ent_buf == SUPER_PW)) begin
              state     <= S_NEW1;
              wrong_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (wrong_cnt == WC_W'(MAX_WRONG - 1)) begin
                state     <= S_LOCKED;
                locking   <= 1'b1;
                tmr       <= '0;
                wrong_cnt <= '0;
              end else begin
                wrong_cnt <= wrong_cnt + WC_W'(1);
              end
            end
          end else if (key_valid && cancel) begin
            ent_buf   <= '0;
            digit_cnt <= '0;
          end else if (key_digit_c) begin
            ent_buf   <= buf_shift_c;
            digit_cnt <= cnt_inc_c;
          end
        end

        S_OPEN: begin
          if (tmr == TMR_W'(OPEN_CYCLES - 1)) begin
            state     <= S_IDLE;
            unlock_ok <= 1'b0;
            tmr       <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_LOCKED: begin
          if (tmr == TMR_W'(LOCK_CYCLES - 1)) begin
            state   <= S_IDLE;
            locking <= 1'b0;
            tmr     <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_NEW1: begin
          if (tmo_hit_c) begin
            state     <= S_IDLE;
            ent_buf   <= '0;
            digit_cnt <= '0;
          end else if (key_valid && confirm) begin
            ent_buf   <= '0;
            digit_cnt <= '0;
            if (len_pw_c) begin
              cand_pw <= ent_buf[PW_W-1:0];
              state   <= S_NEW2;
            end else begin
              err_pulse <= 1'b1;
              state     <= S_IDLE;
            end
          end else if (key_valid && cancel) begin
            state     <= S_IDLE;
            ent_buf   <= '0;
            digit_cnt <= '0;
          end else if (key_digit_c) begin
            ent_buf   <= buf_shift_c;
            digit_cnt <= cnt_inc_c;
          end
        end

        S_NEW2: begin
          if (tmo_hit_c) begin
            state     <= S_IDLE;
            ent_buf   <= '0;
            digit_cnt <= '0;
          end else if (key_valid && confirm) begin
            state     <= S_IDLE;
            ent_buf   <= '0;
            digit_cnt <= '0;
            if (len_pw_c && (ent_buf[PW_W-1:0] == cand_pw)) begin
              user_pw  <= cand_pw;
              reset_ok <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
            end
          end else if (key_valid && cancel) begin
            state     <= S_IDLE;
            ent_buf   <= '0;
            digit_cnt <= '0;
          end else if (key_digit_c) begin
            ent_buf   <= buf_shift_c;
            digit_cnt <= cnt_inc_c;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_code_lock.sv
// Directed self-checking bench for param_code_lock with default parameters.
module tb_param_code_lock;

  localparam int K_CAN  = 16;
  localparam int K_CON  = 17;
  localparam int K_BOTH = 18;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] din = 4'd0;
  logic       cancel = 1'b0;
  logic       confirm = 1'b0;
  logic       unlock_ok, locking, reset_ok, err_pulse;
  logic [1:0] wrong_cnt;
  logic [3:0] digit_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_code_lock dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .key_valid (key_valid),
    .din       (din),
    .cancel    (cancel),
    .confirm   (confirm),
    .unlock_ok (unlock_ok),
    .locking   (locking),
    .reset_ok  (reset_ok),
    .err_pulse (err_pulse),
    .wrong_cnt (wrong_cnt),
    .digit_cnt (digit_cnt)
  );

  // One key strobe: driven at negedge, sampled by DUT at posedge, outputs observed #1 later.
  task automatic press(input int k);
    @(negedge clk);
    key_valid = 1'b1;
    din       = (k < 16) ? 4'(k) : 4'd0;
    cancel    = (k == K_CAN) || (k == K_BOTH);
    confirm   = (k == K_CON) || (k == K_BOTH);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    cancel    = 1'b0;
    confirm   = 1'b0;
    din       = 4'd0;
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic enter_super();
    press(2); press(3); press(0); press(4); press(1); press(9);
  endtask

  // Count consecutive cycles (from now) that the chosen output stays high.
  task automatic measure(input bit sel_lock, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(sel_lock ? locking : unlock_ok)) break;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Let an open/lockout period run out, bounded.
  task automatic wait_quiet();
    for (int i = 0; i < 50; i++) begin
      if (!unlock_ok && !locking) break;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (unlock_ok || locking) begin
      n_err++;
      $display("FAIL wait_quiet: unlock_ok=%0b locking=%0b still high, want 0", unlock_ok, locking);
    end
  endtask

  task automatic test_reset();
    #3 clr_n = 1'b0;
    #1;
    n_vec++;
    if ({unlock_ok, locking, reset_ok, err_pulse, wrong_cnt, digit_cnt} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0", {unlock_ok, locking, reset_ok, err_pulse, wrong_cnt, digit_cnt});
    end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_open();
    int n;
    enter4(1, 2, 3, 4);
    n_vec++; if (digit_cnt !== 4'd4) begin n_err++; $display("FAIL open_digit_cnt: got %0d want 4", digit_cnt); end
    press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL open_latency: unlock_ok=%0b want 1", unlock_ok); end
    n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL open_err: err_pulse=%0b want 0", err_pulse); end
    n_vec++; if (wrong_cnt !== 2'd0) begin n_err++; $display("FAIL open_wrong: got %0d want 0", wrong_cnt); end
    n_vec++; if (digit_cnt !== 4'd0) begin n_err++; $display("FAIL open_clear: digit_cnt=%0d want 0", digit_cnt); end
    measure(1'b0, n);
    n_vec++; if (n != 3) begin n_err++; $display("FAIL open_len: unlock_ok high %0d cycles want 3", n); end
  endtask

  task automatic test_lockout();
    int n;
    for (int i = 1; i <= 3; i++) begin
      enter4(1, 1, 1, 1);
      press(K_CON);
      n_vec++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL lock_err%0d: err_pulse=%0b want 1", i, err_pulse); end
      n_vec++; if (wrong_cnt !== 2'((i < 3) ? i : 0)) begin n_err++; $display("FAIL lock_wrong%0d: got %0d want %0d", i, wrong_cnt, (i < 3) ? i : 0); end
      n_vec++; if (locking !== (i == 3)) begin n_err++; $display("FAIL lock_flag%0d: locking=%0b want %0b", i, locking, i == 3); end
    end
    // Keys land on each locked cycle and must all be ignored.
    for (int j = 0; j < 3; j++) begin
      press(1 + j);
      n_vec++; if (locking !== (j < 2)) begin n_err++; $display("FAIL lock_hold%0d: locking=%0b want %0b", j, locking, j < 2); end
      n_vec++; if (digit_cnt !== 4'd0) begin n_err++; $display("FAIL lock_ignore%0d: digit_cnt=%0d want 0", j, digit_cnt); end
    end
    enter4(1, 2, 3, 4);
    press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL lock_after_open: unlock_ok=%0b want 1", unlock_ok); end
    measure(1'b0, n);
    wait_quiet();
  endtask

  task automatic test_length();
    press(1); press(2); press(3); press(K_CON);
    n_vec++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL short_err: err_pulse=%0b want 1", err_pulse); end
    n_vec++; if (wrong_cnt !== 2'd1) begin n_err++; $display("FAIL short_wrong: got %0d want 1", wrong_cnt); end
    for (int d = 1; d <= 7; d++) press(d);
    n_vec++; if (digit_cnt !== 4'd7) begin n_err++; $display("FAIL ovf_cnt: got %0d want 7", digit_cnt); end
    press(8);
    n_vec++; if (digit_cnt !== 4'd7) begin n_err++; $display("FAIL ovf_sat: got %0d want 7", digit_cnt); end
    press(K_CON);
    n_vec++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL ovf_err: err_pulse=%0b want 1", err_pulse); end
    n_vec++; if (wrong_cnt !== 2'd2) begin n_err++; $display("FAIL ovf_wrong: got %0d want 2", wrong_cnt); end
    enter4(1, 2, 3, 4); press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL len_open: unlock_ok=%0b want 1", unlock_ok); end
    n_vec++; if (wrong_cnt !== 2'd0) begin n_err++; $display("FAIL len_clear: wrong_cnt=%0d want 0", wrong_cnt); end
    wait_quiet();
  endtask

  task automatic test_code_change();
    enter_super(); press(K_CON);
    n_vec++; if ({unlock_ok, err_pulse, locking} !== 3'b000) begin n_err++; $display("FAIL super_flags: got %b want 000", {unlock_ok, err_pulse, locking}); end
    enter4(5, 6, 7, 8); press(K_CON);
    n_vec++; if ({err_pulse, reset_ok} !== 2'b00) begin n_err++; $display("FAIL new1_flags: got %b want 00", {err_pulse, reset_ok}); end
    enter4(5, 6, 7, 8); press(K_CON);
    n_vec++; if (reset_ok !== 1'b1) begin n_err++; $display("FAIL new2_reset_ok: got %0b want 1", reset_ok); end
    @(posedge clk); #1;
    n_vec++; if (reset_ok !== 1'b0) begin n_err++; $display("FAIL reset_ok_pulse: got %0b want 0", reset_ok); end
    enter4(1, 2, 3, 4); press(K_CON);
    n_vec++; if (err_pulse !== 1'b1 || unlock_ok !== 1'b0) begin n_err++; $display("FAIL old_code: err=%0b unlock=%0b want 1 0", err_pulse, unlock_ok); end
    enter4(5, 6, 7, 8); press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL new_code_open: unlock_ok=%0b want 1", unlock_ok); end
    n_vec++; if (wrong_cnt !== 2'd0) begin n_err++; $display("FAIL new_code_wrong: got %0d want 0", wrong_cnt); end
    wait_quiet();
  endtask

  task automatic test_async_reset();
    enter4(5, 6, 7, 8); press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL pre_rst_open: unlock_ok=%0b want 1", unlock_ok); end
    @(negedge clk); clr_n = 1'b0; #1;
    n_vec++; if ({unlock_ok, locking, reset_ok, err_pulse, wrong_cnt, digit_cnt} !== 10'd0) begin n_err++; $display("FAIL rst_open: got %b want 0", {unlock_ok, locking, reset_ok, err_pulse, wrong_cnt, digit_cnt}); end
    @(negedge clk); clr_n = 1'b1;
    enter4(1, 2, 3, 4); press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL rst_default_code: unlock_ok=%0b want 1", unlock_ok); end
    wait_quiet();
    enter_super(); press(K_CON);
    enter4(5, 6, 7, 8); press(K_CON);
    press(5); press(6);
    n_vec++; if (digit_cnt !== 4'd2) begin n_err++; $display("FAIL new2_digits: got %0d want 2", digit_cnt); end
    @(negedge clk); clr_n = 1'b0; #1;
    n_vec++; if ({unlock_ok, locking, reset_ok, err_pulse, wrong_cnt, digit_cnt} !== 10'd0) begin n_err++; $display("FAIL rst_new2: got %b want 0", {unlock_ok, locking, reset_ok, err_pulse, wrong_cnt, digit_cnt}); end
    @(negedge clk); clr_n = 1'b1;
    enter4(5, 6, 7, 8); press(K_CON);
    n_vec++; if (err_pulse !== 1'b1 || wrong_cnt !== 2'd1) begin n_err++; $display("FAIL rst_aborted_change: err=%0b wrong=%0d want 1 1", err_pulse, wrong_cnt); end
    enter4(1, 2, 3, 4); press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL rst_code_kept: unlock_ok=%0b want 1", unlock_ok); end
    wait_quiet();
  endtask

  task automatic test_mismatch();
    enter_super(); press(K_CON);
    enter4(5, 6, 7, 8); press(K_CON);
    enter4(5, 6, 7, 9); press(K_CON);
    n_vec++; if ({err_pulse, reset_ok} !== 2'b10) begin n_err++; $display("FAIL mismatch_flags: got %b want 10", {err_pulse, reset_ok}); end
    n_vec++; if (wrong_cnt !== 2'd0) begin n_err++; $display("FAIL mismatch_wrong: got %0d want 0", wrong_cnt); end
    enter4(1, 2, 3, 4); press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL mismatch_code_kept: unlock_ok=%0b want 1", unlock_ok); end
    wait_quiet();
  endtask

  task automatic test_cancel_priority();
    press(1); press(2); press(K_CAN);
    n_vec++; if (digit_cnt !== 4'd0) begin n_err++; $display("FAIL cancel_clear: digit_cnt=%0d want 0", digit_cnt); end
    press(3); press(4); press(K_CON);
    n_vec++; if (err_pulse !== 1'b1 || wrong_cnt !== 2'd1) begin n_err++; $display("FAIL cancel_then_fail: err=%0b wrong=%0d want 1 1", err_pulse, wrong_cnt); end
    press(1); press(12);
    n_vec++; if (digit_cnt !== 4'd1) begin n_err++; $display("FAIL bad_digit_ignored: digit_cnt=%0d want 1", digit_cnt); end
    press(2); press(3); press(4); press(K_BOTH);
    n_vec++; if (unlock_ok !== 1'b1 || wrong_cnt !== 2'd0) begin n_err++; $display("FAIL confirm_over_cancel: unlock=%0b wrong=%0d want 1 0", unlock_ok, wrong_cnt); end
    wait_quiet();
  endtask

  task automatic test_timeout();
    press(9); press(K_CON);
    press(1); press(2);
    repeat (15) @(posedge clk);
    #1;
    n_vec++; if (digit_cnt !== 4'd2) begin n_err++; $display("FAIL tmo_early: digit_cnt=%0d want 2", digit_cnt); end
    @(posedge clk); #1;
    n_vec++; if (digit_cnt !== 4'd0 || err_pulse !== 1'b0) begin n_err++; $display("FAIL tmo_fire: cnt=%0d err=%0b want 0 0", digit_cnt, err_pulse); end
    n_vec++; if (wrong_cnt !== 2'd1) begin n_err++; $display("FAIL tmo_wrong: got %0d want 1", wrong_cnt); end
    enter4(1, 2, 3, 4); press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL tmo_open: unlock_ok=%0b want 1", unlock_ok); end
    wait_quiet();
    enter_super(); press(K_CON);
    repeat (16) @(posedge clk);
    #1;
    enter4(1, 2, 3, 4); press(K_CON);
    n_vec++; if (unlock_ok !== 1'b1) begin n_err++; $display("FAIL tmo_new1_exit: unlock_ok=%0b want 1", unlock_ok); end
    wait_quiet();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_open();
    test_lockout();
    test_length();
    test_code_change();
    test_async_reset();
    test_mismatch();
    test_cancel_priority();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_code_lock.md
Name: param_code_lock

Overview:
- Parametrised successor to the team's 4-digit coded lock.
- Takes keypad events (digit, cancel, confirm) qualified by a valid strobe.
- Supports N-digit user code, M-digit super code, two-pass code change, configurable wrong-attempt limit, open/lockout durations and inter-key timeout.
- Sits between the keypad debouncer/encoder and the door actuator / status LEDs.

Parameters:
- PW_LEN, 4, user code length in digits (1..8).
- SUPER_LEN, 6, super code length in digits (PW_LEN+1..8).
- DEFAULT_PW, 16'h1234, reset user code; PW_LEN*4 bits, first-entered digit in MSB nibble.
- SUPER_PW, 24'h230419, fixed super code; SUPER_LEN*4 bits, same packing.
- MAX_WRONG, 3, consecutive failed confirms that trigger lockout (>=1).
- OPEN_CYCLES, 3, cycles unlock_ok is held high (>=1).
- LOCK_CYCLES, 3, cycles locking is held high (>=1).
- TIMEOUT_CYCLES, 16, idle cycles after which partial input is discarded (>=2).

Ports:
- clk, input, 1, system clock, rising edge.
- clr_n, input, 1, reset, asynchronous, active-low.
- key_valid, input, 1, one-cycle strobe; din/cancel/confirm are sampled only when high.
- din, input, 4, digit value; 0..9 valid, 10..15 ignored.
- cancel, input, 1, '*' key.
- confirm, input, 1, '#' key.
- unlock_ok, output, 1, lock open.
- locking, output, 1, lockout active.
- reset_ok, output, 1, one-cycle pulse: code change committed.
- err_pulse, output, 1, one-cycle pulse: failed confirm (wrong code, bad length, or change-confirm mismatch).
- wrong_cnt, output, clog2(MAX_WRONG+1), current consecutive-failure count.
- digit_cnt, output, 4, digits buffered in the current entry.

Behaviour:
- Reset (clr_n low, async): state=IDLE; unlock_ok=0, locking=0, reset_ok=0, err_pulse=0, wrong_cnt=0, digit_cnt=0; user code = DEFAULT_PW; entry buffer and timers cleared. Reset asserted mid-operation aborts everything, including an uncommitted code change.
- Key priority within one valid strobe: confirm > cancel > digit. Cycles with key_valid=0 have no key effect.
- Entry buffer: SUPER_LEN-nibble shift register; each digit shifts in at LSB. digit_cnt saturates at SUPER_LEN+1 (overflow marker); a confirm in the overflow state always fails.
- States: IDLE, OPEN, LOCKED, NEW1, NEW2.
- IDLE, digit: buffer it.
- IDLE, cancel: clear buffer; wrong_cnt unchanged.
- IDLE, confirm:
  - digit_cnt==PW_LEN and low PW_LEN nibbles == user code -> OPEN; unlock_ok=1 next cycle; wrong_cnt=0.
  - digit_cnt==SUPER_LEN and buffer == SUPER_PW -> NEW1; wrong_cnt=0.
  - Any other case is a failure: err_pulse=1 and wrong_cnt+1. When the count reaches MAX_WRONG -> LOCKED, locking=1, wrong_cnt=0.
  - Confirm with digit_cnt==0 is a failure.
  - Buffer is cleared after every confirm.
- OPEN: unlock_ok high for exactly OPEN_CYCLES cycles, then -> IDLE. All keys are ignored; no buffering.
- LOCKED: locking high for exactly LOCK_CYCLES cycles, then -> IDLE. All keys are ignored.
- NEW1: buffer digits.
  - Confirm with digit_cnt==PW_LEN latches the candidate code -> NEW2.
  - Confirm with any other digit_cnt: err_pulse -> IDLE.
  - Cancel -> IDLE.
- NEW2: buffer digits.
  - Confirm with digit_cnt==PW_LEN and match to candidate: user code updated, reset_ok=1 for one cycle -> IDLE. The new code takes effect from the next cycle.
  - Any other confirm: err_pulse -> IDLE; code unchanged.
  - Cancel -> IDLE.
  - NEW1/NEW2 failures never increment wrong_cnt.
- Timeout:
  - In IDLE with digit_cnt>0, or in NEW1/NEW2: an idle counter is reloaded on every valid key.
  - After TIMEOUT_CYCLES consecutive cycles without key_valid: buffer cleared, state -> IDLE.
  - No err_pulse; wrong_cnt unchanged.
- Outputs are registered. Latency from the confirm strobe to unlock_ok/locking/reset_ok/err_pulse is 1 cycle.

Test Plan:
- Defaults: keys 1,2,3,4,# -> unlock_ok high exactly 3 cycles starting 1 cycle after #; wrong_cnt=0; no err_pulse.
- Lockout: three sequences 1,1,1,1,# -> err_pulse x3; locking high 3 cycles after the 3rd; keys 1,2,3,4,# during lockout have no effect; afterwards 1,2,3,4,# opens.
- Length errors:
  - 1,2,3,# -> err_pulse, wrong_cnt=1.
  - 1,2,3,4,5,6,7,# (overflow) -> err_pulse, wrong_cnt=2.
  - 1,2,3,4,# -> opens and clears wrong_cnt.
- Code change:
  - 2,3,0,4,1,9,#, then 5,6,7,8,#, then 5,6,7,8,# -> reset_ok one-cycle pulse.
  - Old code 1,2,3,4,# then fails; 5,6,7,8,# opens.
  - Mismatched second pass 5,6,7,9,# -> err_pulse; code stays 1234.
- Cancel/priority/timeout:
  - 1,2,* then 3,4,# -> fails.
  - Confirm+cancel in the same strobe acts as confirm.
  - 1,2 followed by 16 idle cycles, then 1,2,3,4,# -> opens; wrong_cnt unchanged.
- Async reset: assert clr_n mid-OPEN and mid-NEW2 -> all outputs 0 immediately; code returns to 1234.
